// File: rtl/midori_pkg.sv
// Midori64 key-schedule constants and the round-constant expansion.
package midori_pkg;

  localparam int NROUNDS = 15;
  localparam int IDXW    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [15:0] RC [NROUNDS] = '{
    16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
    16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
    16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90
  };

  // RC bit j lands in the LSB of nibble j, where nibble 0 is bits 63:60.
  function automatic logic [63:0] expand_rc(input logic [15:0] rc);
    logic [63:0] x;
    x = '0;
    for (int j = 0; j < 16; j++) begin
      x[60 - 4*j] = rc[j];
    end
    return x;
  endfunction

endpackage

// File: rtl/midori_rc_rom.sv
// Combinational round-constant lookup; index 15 returns 0.
module midori_rc_rom
  import midori_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [15:0] rc
);

  always_comb begin
    rc = '0;
    for (int i = 0; i < NROUNDS; i++) begin
      if (idx == 4'(i)) rc = RC[i];
    end
  end

endmodule

// File: rtl/midori64_key_sequencer.sv
// Latches a Midori64 master key and issues WK plus RK_0..14 in either order,
// one key per accepted next, with a done pulse after the final key.
module midori64_key_sequencer
  import midori_pkg::*;
#(
  parameter int NROUNDS = midori_pkg::NROUNDS,
  parameter int IDXW    = midori_pkg::IDXW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    key_in,
  input  logic            load,
  input  logic            dec,
  input  logic            next,
  output logic [63:0]     wk_out,
  output logic [63:0]     rk_out,
  output logic [IDXW-1:0] round_idx,
  output logic            rk_valid,
  output logic            last,
  output logic            done
);

  state_t            state;
  logic [63:0]       k0, k1;
  logic              dec_q;
  logic [IDXW-1:0]   start_idx, step_idx, final_idx, lut_idx;
  logic [15:0]       rc;
  logic [63:0]       key_half, rk_new;

  assign start_idx = dec ? IDXW'(NROUNDS - 1) : '0;
  assign step_idx  = dec_q ? round_idx - 1'b1 : round_idx + 1'b1;
  assign final_idx = dec_q ? '0 : IDXW'(NROUNDS - 1);

  // On load the key registers are not yet written, so use key_in directly.
  assign lut_idx  = load ? start_idx : step_idx;
  assign key_half = lut_idx[0] ? (load ? key_in[63:0]   : k1)
                               : (load ? key_in[127:64] : k0);
  assign rk_new   = key_half ^ expand_rc(rc);

  midori_rc_rom u_rc_rom (
    .idx (lut_idx[3:0]),
    .rc  (rc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k0        <= '0;
      k1        <= '0;
      dec_q     <= 1'b0;
      wk_out    <= '0;
      rk_out    <= '0;
      round_idx <= '0;
      rk_valid  <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        k0        <= key_in[127:64];
        k1        <= key_in[63:0];
        dec_q     <= dec;
        wk_out    <= key_in[127:64] ^ key_in[63:0];
        round_idx <= start_idx;
        rk_out    <= rk_new;
        rk_valid  <= 1'b1;
        last      <= 1'b0;
        state     <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (next) begin
              if (last) begin
                rk_valid <= 1'b0;
                last     <= 1'b0;
                done     <= 1'b1;
                state    <= FIN;
              end else begin
                round_idx <= step_idx;
                rk_out    <= rk_new;
                last      <= (step_idx == final_idx);
              end
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midori64_key_sequencer.sv
// Directed bench for midori64_key_sequencer with an independent key-schedule model.
module tb_midori64_key_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         load = 1'b0;
  logic         dec = 1'b0;
  logic         next = 1'b0;
  logic [63:0]  wk_out, rk_out;
  logic [3:0]   round_idx;
  logic         rk_valid, last, done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic [15:0] tb_rc [15] = '{
    16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
    16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
    16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90
  };
  logic [63:0] enc_rk [15];

  midori64_key_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .load      (load),
    .dec       (dec),
    .next      (next),
    .wk_out    (wk_out),
    .rk_out    (rk_out),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .last      (last),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Shift nibbles in from the right: RC bit 0 ends up in the top nibble.
  function automatic logic [63:0] tb_expand(input logic [15:0] rc);
    logic [63:0] e;
    e = '0;
    for (int n = 0; n < 16; n++) e = {e[59:0], 3'b000, rc[n]};
    return e;
  endfunction

  function automatic logic [63:0] tb_rk(input logic [127:0] k, input int i);
    logic [63:0] half;
    half = (i % 2 == 1) ? k[63:0] : k[127:64];
    return half ^ tb_expand(tb_rc[i]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k, input logic d);
    key_in = k; dec = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    step();
    checks++;
    if ({wk_out, rk_out, round_idx, rk_valid, last, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got wk=%h rk=%h idx=%0d v=%b l=%b d=%b, expected all 0",
               wk_out, rk_out, round_idx, rk_valid, last, done);
    end
  endtask

  task automatic test_encrypt();
    do_load(KEY_A, 1'b0);
    checks++;
    if (wk_out !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++; $display("FAIL enc_wk: got %h expected ffffffffffffffff", wk_out);
    end
    checks++;
    if (rk_out !== 64'h1023546699BBDDEF) begin
      errors++; $display("FAIL enc_rk0_literal: got %h expected 1023546699bbddef", rk_out);
    end
    next = 1'b1;
    for (int i = 0; i < 15; i++) begin
      enc_rk[i] = rk_out;
      checks++;
      if (rk_valid !== 1'b1 || round_idx !== 4'(i) || rk_out !== tb_rk(KEY_A, i)
          || last !== (i == 14) || done !== 1'b0) begin
        errors++;
        $display("FAIL enc_step%0d: got v=%b idx=%0d rk=%h l=%b d=%b, expected v=1 idx=%0d rk=%h l=%b d=0",
                 i, rk_valid, round_idx, rk_out, last, done, i, tb_rk(KEY_A, i), (i == 14));
      end
      if (i == 1) begin
        checks++;
        if (rk_out !== 64'hFEDCBA8976552300) begin
          errors++; $display("FAIL enc_rk1_literal: got %h expected fedcba8976552300", rk_out);
        end
      end
      step();
    end
    next = 1'b0;
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || last !== 1'b0) begin
      errors++; $display("FAIL enc_done: got d=%b v=%b l=%b expected d=1 v=0 l=0", done, rk_valid, last);
    end
    step();
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL enc_done_once: got d=%b v=%b expected d=0 v=0", done, rk_valid);
    end
  endtask

  task automatic test_decrypt();
    do_load(KEY_A, 1'b1);
    checks++;
    if (round_idx !== 4'd14 || rk_out !== 64'h0123556698BADDFE || rk_valid !== 1'b1) begin
      errors++;
      $display("FAIL dec_first: got idx=%0d rk=%h v=%b expected idx=14 rk=0123556698baddfe v=1",
               round_idx, rk_out, rk_valid);
    end
    next = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      checks++;
      if (round_idx !== 4'(i) || rk_out !== enc_rk[i] || rk_out !== tb_rk(KEY_A, i)
          || last !== (i == 0) || done !== 1'b0) begin
        errors++;
        $display("FAIL dec_step%0d: got idx=%0d rk=%h l=%b d=%b expected idx=%0d rk=%h l=%b d=0",
                 i, round_idx, rk_out, last, done, i, tb_rk(KEY_A, i), (i == 0));
      end
      step();
    end
    next = 1'b0;
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL dec_done: got d=%b v=%b expected d=1 v=0", done, rk_valid);
    end
    step();
  endtask

  task automatic test_stall();
    do_load(KEY_A, 1'b0);
    next = 1'b1;
    for (int i = 0; i < 7; i++) step();
    next = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (round_idx !== 4'd7 || rk_out !== tb_rk(KEY_A, 7) || rk_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got idx=%0d rk=%h v=%b expected idx=7 rk=%h v=1",
                 c, round_idx, rk_out, rk_valid, tb_rk(KEY_A, 7));
      end
    end
    next = 1'b1;
    for (int i = 7; i < 15; i++) step();
    next = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL stall_done: got d=%b expected 1", done);
    end
    step();
  endtask

  task automatic test_idle_next();
    logic [63:0] rk_before;
    logic [3:0]  idx_before;
    rk_before  = rk_out;
    idx_before = round_idx;
    next = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (rk_valid !== 1'b0 || done !== 1'b0 || last !== 1'b0 || wk_out !== 64'hFFFFFFFFFFFFFFFF
          || rk_out !== rk_before || round_idx !== idx_before) begin
        errors++;
        $display("FAIL idle_next%0d: got v=%b d=%b l=%b wk=%h rk=%h idx=%0d expected v=0 d=0 l=0 wk=ffffffffffffffff rk=%h idx=%0d",
                 c, rk_valid, done, last, wk_out, rk_out, round_idx, rk_before, idx_before);
      end
    end
    next = 1'b0;
  endtask

  task automatic test_load_priority();
    do_load(KEY_A, 1'b0);
    next = 1'b1;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (round_idx !== 4'd9) begin
      errors++; $display("FAIL prio_setup: got idx=%0d expected 9", round_idx);
    end
    key_in = '0; dec = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    next = 1'b0;
    checks++;
    if (round_idx !== 4'd0 || rk_out !== 64'h1100110110101000 || wk_out !== 64'h0
        || done !== 1'b0 || rk_valid !== 1'b1) begin
      errors++;
      $display("FAIL prio_restart: got idx=%0d rk=%h wk=%h d=%b v=%b expected idx=0 rk=1100110110101000 wk=0 d=0 v=1",
               round_idx, rk_out, wk_out, done, rk_valid);
    end
  endtask

  task automatic test_zero_sweep();
    next = 1'b1;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (round_idx !== 4'(i) || rk_out !== tb_expand(tb_rc[i])
          || (rk_out & ~64'h1111111111111111) !== 64'h0 || done !== 1'b0) begin
        errors++;
        $display("FAIL zero_rk%0d: got idx=%0d rk=%h d=%b expected idx=%0d rk=%h d=0",
                 i, round_idx, rk_out, done, i, tb_expand(tb_rc[i]));
      end
      step();
    end
    next = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL zero_done: got d=%b expected 1", done);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    do_load(KEY_A, 1'b0);
    next = 1'b1;
    for (int i = 0; i < 5; i++) step();
    next = 1'b0;
    checks++;
    if (round_idx !== 4'd5 || rk_valid !== 1'b1) begin
      errors++; $display("FAIL rst_setup: got idx=%0d v=%b expected idx=5 v=1", round_idx, rk_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({wk_out, rk_out, round_idx, rk_valid, last, done} !== '0) begin
      errors++;
      $display("FAIL rst_async: got wk=%h rk=%h idx=%0d v=%b l=%b d=%b expected all 0",
               wk_out, rk_out, round_idx, rk_valid, last, done);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (rk_valid !== 1'b0 || round_idx !== 4'd0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_release: got v=%b idx=%0d d=%b expected 0 0 0", rk_valid, round_idx, done);
    end
    next = 1'b1;
    step();
    step();
    next = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || done !== 1'b0 || rk_out !== 64'h0) begin
      errors++; $display("FAIL rst_idle: got v=%b d=%b rk=%h expected v=0 d=0 rk=0", rk_valid, done, rk_out);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_stall();
    test_idle_next();
    test_load_priority();
    test_zero_sweep();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/midori64_key_sequencer.md
Name: midori64_key_sequencer

Overview:
- Round-key sequencer that sits directly upstream of the Midori64 iterative round datapath.
- Latches a 128-bit master key, outputs the whitening key WK = K0^K1, and steps through the 15 round keys RK_i = K_(i mod 2) ^ expand(RC[i]), one per `next` request.
- Supports encryption order (i = 0..14) and decryption order (i = 14..0), so the round datapath never holds the key or the constant table itself.

Parameters:
- NROUNDS, 15, number of round keys issued per block (Midori64).
- IDXW, 4, width of the round index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- key_in  input  128  master key; K0 = key_in[127:64], K1 = key_in[63:0].
- load  input  1  single-cycle pulse; latches key_in and dec, then starts a sequence.
- dec  input  1  order select, sampled only on load: 0 = ascending, 1 = descending.
- next  input  1  consumer accepted the current rk_out; advance.
- wk_out  output  64  registered whitening key K0^K1, stable until the next load.
- rk_out  output  64  registered current round key.
- round_idx  output  IDXW  index i of rk_out.
- rk_valid  output  1  rk_out and round_idx are valid.
- last  output  1  rk_valid and current key is the final one of the sequence.
- done  output  1  one-cycle pulse after the final key is accepted.

Behaviour:
- Reset (async, rst=1) clears all state and outputs to 0: wk_out, rk_out, round_idx, rk_valid, last, done; FSM goes to IDLE.
- FSM states:
  - IDLE: rk_valid=0.
  - RUN: rk_valid=1.
  - FIN: one cycle; done=1, then IDLE.
- load, any state: K0, K1, dec_q and wk_out are registered at edge t. From t+1: rk_valid=1, round_idx=0 (dec=0) or 14 (dec=1), rk_out=RK of that index, state RUN. Load latency is 1 cycle.
- load has priority over next in the same cycle; a load mid-sequence aborts the sequence and restarts it without asserting done.
- next in RUN, not last: round_idx steps ±1 and rk_out updates at the same edge, so the new key is valid the cycle after next. Back-to-back next gives one key per cycle.
- next in RUN with last=1: go to FIN. rk_valid=0 from the next cycle, done=1 for exactly that one cycle, then IDLE.
- next in IDLE or FIN is ignored; no wrap-around past 14 or below 0.
- rk_out = (i even ? K0 : K1) ^ expand(RC[i]). expand places bit j of the 16-bit RC into bit 0 (LSB) of nibble j; nibble 0 = bits 63:60 and nibble 15 = bits 3:0. All other bits are 0.
- last = rk_valid & (round_idx == (dec_q ? 0 : NROUNDS-1)).
- Decryption order issues the raw RK_i. Any inverse linear transform of round keys belongs to the round datapath, not this block.
- key_in and dec changes outside a load cycle have no effect.

Decomposition:
- Shared package midori_pkg:
  - NROUNDS.
  - The 15 16-bit Midori64 round constants RC[0..14], taken from the Midori specification.
  - Function expand_rc(16b) -> 64b.
- One natural sub-module: midori_rc_rom, a combinational index (4b) -> 16b constant lookup that returns 0 for index 15. It is shared with any later unrolled core.

Test Plan:
- Reset mid-RUN: assert rst asynchronously at round_idx=5 -> all outputs 0 before the next clk edge; after release, state is IDLE and rk_valid=0.
- Encrypt order: load with key_in = 0x0123456789ABCDEF_FEDCBA9876543210, dec=0, then next held high 15 cycles:
  - wk_out = 0xFFFFFFFFFFFFFFFF.
  - round_idx 0..14 on consecutive cycles.
  - RK_0 = 0x0123456789ABCDEF ^ expand_rc(RC[0]); RK_1 = 0xFEDCBA9876543210 ^ expand_rc(RC[1]).
  - last only at idx 14; done pulses once on the cycle after idx 14 is accepted.
- Decrypt order: same key, dec=1 -> first key is idx 14 = K0 ^ expand_rc(RC[14]); sequence descends to 0; last at idx 0; rk_out for each idx matches the encrypt run.
- Stall: next low for 3 cycles at idx 7 -> rk_out and round_idx hold; a stray next in IDLE leaves all outputs unchanged.
- Load priority: load and next together at idx 9, with key_in = 0 -> next cycle has round_idx=0, rk_out = expand_rc(RC[0]), wk_out = 0, and no done pulse.
- Zero key full sweep: key_in=0 -> every rk_out equals expand_rc(RC[i]). Output is compared bit-exact against the midori_pkg table, checking that only nibble LSBs are set.
